// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Owner tags identify which requester a read result belongs to.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    // Saturating increment for the fetch starvation counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Delay line carrying the owner tag of each memory access alongside the BRAM read latency.
// Cleared to OWN_NONE on reset, so reads in flight at reset never return.
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out
);

    own_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= own_t'(tag_in);
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port BRAM between instruction fetch and data access, one access per cycle.
// Data wins by default; a saturating starvation counter forces a fetch grant after MAX_STARVE denials.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_douta
);

    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    logic [3:0] starve_cnt;
    logic [1:0] tag_in;
    logic [1:0] tag_out;

    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_wea  = 1'b0;
        tag_in   = OWN_NONE;
        if (!reset) begin
            if (if_req && starve_cnt == STARVE_LIM) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
        if (if_gnt) begin
            mem_addr = if_addr;
            tag_in   = OWN_IF;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            mem_din  = d_wdata;
            mem_wea  = d_we;
            // Stores complete on their grant and never return data.
            tag_in   = d_we ? OWN_NONE : OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || if_gnt) begin
            starve_cnt <= 4'd0;
        end else if (if_req && d_gnt) begin
            starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Tag reaching the end of the pipe is qualified by reset so a result arriving during reset is dropped.
    assign if_valid = !reset && (tag_out == OWN_IF);
    assign d_valid  = !reset && (tag_out == OWN_D);
    assign if_rdata = if_valid ? mem_douta : '0;
    assign d_rdata  = d_valid  ? mem_douta : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one RD_LAT=1 instance for the main scenarios,
// one RD_LAT=3 instance for the mid-flight reset case, each backed by a behavioural BRAM.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: RD_LAT = 1
    logic        reset = 1'b1;
    logic        if_req = 1'b0, if_gnt, if_valid;
    logic [9:0]  if_addr = '0;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_valid;
    logic [9:0]  d_addr = '0;
    logic [15:0] d_wdata = '0, d_rdata;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din, mem_douta;
    logic        mem_wea;
    logic [15:0] mem_a [1024];

    // Instance B: RD_LAT = 3
    logic        b_reset = 1'b1;
    logic        b_if_req = 1'b0, b_if_gnt, b_if_valid;
    logic [9:0]  b_if_addr = '0;
    logic [15:0] b_if_rdata;
    logic        b_d_gnt, b_d_valid;
    logic [15:0] b_d_rdata;
    logic [9:0]  b_mem_addr;
    logic [15:0] b_mem_din, b_mem_douta, b_rd1, b_rd2;
    logic        b_mem_wea;
    logic [15:0] mem_b [1024];

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1), .MAX_STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea), .mem_douta(mem_douta)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(3), .MAX_STARVE(4)) dut_b (
        .clk(clk), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(10'd0), .d_wdata(16'd0),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_wea(b_mem_wea), .mem_douta(b_mem_douta)
    );

    // Behavioural BRAMs, read-first, with 1 and 3 cycles of read latency.
    always @(posedge clk) begin
        if (mem_wea) mem_a[mem_addr] <= mem_din;
        mem_douta <= mem_a[mem_addr];
        if (b_mem_wea) mem_b[b_mem_addr] <= b_mem_din;
        b_rd1 <= mem_b[b_mem_addr];
        b_rd2 <= b_rd1;
        b_mem_douta <= b_rd2;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; if_addr = 10'd1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++; if (if_gnt !== 1'b0) begin fails++; $display("FAIL reset_if_gnt c%0d: got %b want 0", c, if_gnt); end
            tests++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL reset_d_gnt c%0d: got %b want 0", c, d_gnt); end
            tests++; if (mem_wea !== 1'b0) begin fails++; $display("FAIL reset_mem_wea c%0d: got %b want 0", c, mem_wea); end
            tests++; if (mem_addr !== 10'd0) begin fails++; $display("FAIL reset_mem_addr c%0d: got %h want 000", c, mem_addr); end
            tests++; if ({if_valid, d_valid} !== 2'b00) begin fails++; $display("FAIL reset_valid c%0d: got %b want 00", c, {if_valid, d_valid}); end
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        tests++; if ({if_gnt, d_gnt} !== 2'b01) begin fails++; $display("FAIL first_grant: got if/d %b want 01", {if_gnt, d_gnt}); end
        tests++; if (mem_addr !== 10'd5) begin fails++; $display("FAIL first_grant_addr: got %h want 005", mem_addr); end
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        tests++; if (d_valid !== 1'b1) begin fails++; $display("FAIL first_load_valid: got %b want 1", d_valid); end
        tests++; if (d_rdata !== 16'h0055) begin fails++; $display("FAIL first_load_data: got %h want 0055", d_rdata); end
        next_cycle();
    endtask

    task automatic test_fetch_only();
        do_reset();
        if_req = 1'b1; if_addr = 10'd1;
        @(negedge clk);
        tests++; if (if_gnt !== 1'b1) begin fails++; $display("FAIL fetch_gnt: got %b want 1", if_gnt); end
        tests++; if (mem_addr !== 10'd1 || mem_wea !== 1'b0) begin fails++; $display("FAIL fetch_mem: got addr %h wea %b want 001 0", mem_addr, mem_wea); end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL fetch_valid: got %b want 1", if_valid); end
        tests++; if (if_rdata !== 16'h1000) begin fails++; $display("FAIL fetch_rdata: got %h want 1000", if_rdata); end
        tests++; if (d_valid !== 1'b0 || d_rdata !== 16'h0) begin fails++; $display("FAIL fetch_d_quiet: got %b %h want 0 0000", d_valid, d_rdata); end
        next_cycle();
    endtask

    task automatic test_contention();
        do_reset();
        if_req = 1'b1; if_addr = 10'd2;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd3; d_wdata = 16'hAC00;
        @(negedge clk);
        tests++; if ({if_gnt, d_gnt} !== 2'b01) begin fails++; $display("FAIL cont_store_gnt: got if/d %b want 01", {if_gnt, d_gnt}); end
        tests++; if (mem_wea !== 1'b1 || mem_addr !== 10'd3 || mem_din !== 16'hAC00) begin fails++; $display("FAIL cont_store_mem: got wea %b addr %h din %h want 1 003 ac00", mem_wea, mem_addr, mem_din); end
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        tests++; if ({if_gnt, d_gnt} !== 2'b10) begin fails++; $display("FAIL cont_fetch_gnt: got if/d %b want 10", {if_gnt, d_gnt}); end
        tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL cont_store_novalid: got %b want 0", d_valid); end
        next_cycle();
        if_req = 1'b0; d_req = 1'b1; d_addr = 10'd3;
        @(negedge clk);
        tests++; if (if_valid !== 1'b1 || if_rdata !== 16'h8C00) begin fails++; $display("FAIL cont_fetch_data: got %b %h want 1 8c00", if_valid, if_rdata); end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        tests++; if (d_valid !== 1'b1 || d_rdata !== 16'hAC00) begin fails++; $display("FAIL cont_load_back: got %b %h want 1 ac00", d_valid, d_rdata); end
        next_cycle();
    endtask

    task automatic test_starvation();
        do_reset();
        if_req = 1'b1; if_addr = 10'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (if_gnt !== (c == 4 || c == 9) || d_gnt !== !(c == 4 || c == 9)) begin
                fails++; $display("FAIL starve_c%0d: got if/d %b%b want %b%b", c, if_gnt, d_gnt, (c == 4 || c == 9), !(c == 4 || c == 9));
            end
            if (c == 5) begin
                tests++; if (dut.starve_cnt !== 4'd0) begin fails++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
            end
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd2;
        @(negedge clk);
        tests++; if (d_gnt !== 1'b1) begin fails++; $display("FAIL b2b_d_gnt: got %b want 1", d_gnt); end
        next_cycle();
        d_req = 1'b0; if_req = 1'b1; if_addr = 10'd1;
        @(negedge clk);
        tests++; if (d_valid !== 1'b1 || d_rdata !== 16'h8C00) begin fails++; $display("FAIL b2b_d_data: got %b %h want 1 8c00", d_valid, d_rdata); end
        tests++; if (if_valid !== 1'b0 || if_rdata !== 16'h0) begin fails++; $display("FAIL b2b_if_early: got %b %h want 0 0000", if_valid, if_rdata); end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        tests++; if (if_valid !== 1'b1 || if_rdata !== 16'h1000) begin fails++; $display("FAIL b2b_if_data: got %b %h want 1 1000", if_valid, if_rdata); end
        tests++; if (d_valid !== 1'b0 || d_rdata !== 16'h0) begin fails++; $display("FAIL b2b_d_late: got %b %h want 0 0000", d_valid, d_rdata); end
        next_cycle();
    endtask

    task automatic test_wrap_idle();
        do_reset();
        if_req = 1'b1; if_addr = 10'h3FF;
        @(negedge clk);
        tests++; if (mem_addr !== 10'h3FF) begin fails++; $display("FAIL wrap_addr: got %h want 3ff", mem_addr); end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        tests++; if (if_rdata !== 16'h5A5A) begin fails++; $display("FAIL wrap_data: got %h want 5a5a", if_rdata); end
        tests++; if ({if_gnt, d_gnt, mem_wea} !== 3'b000 || mem_addr !== 10'd0 || mem_din !== 16'd0) begin fails++; $display("FAIL idle_mem: got gnt/wea %b addr %h din %h want 000 000 0000", {if_gnt, d_gnt, mem_wea}, mem_addr, mem_din); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        if_req = 1'b1; if_addr = 10'd1;
        @(negedge clk);
        tests++; if (if_gnt !== 1'b1) begin fails++; $display("FAIL mid1_gnt: got %b want 1", if_gnt); end
        next_cycle();
        if_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL mid1_valid_n1: got %b want 0", if_valid); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL mid1_valid_n2: got %b want 0", if_valid); end
        next_cycle();

        // RD_LAT = 3: an undisturbed fetch returns at N+3, then one reset at N+2 suppresses it.
        b_reset = 1'b0;
        b_if_req = 1'b1; b_if_addr = 10'd1;
        @(negedge clk);
        tests++; if (b_if_gnt !== 1'b1) begin fails++; $display("FAIL lat3_gnt: got %b want 1", b_if_gnt); end
        next_cycle();
        b_if_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests++; if (b_if_valid !== (c == 3)) begin fails++; $display("FAIL lat3_valid_n%0d: got %b want %b", c, b_if_valid, (c == 3)); end
            next_cycle();
        end
        tests++; if (b_if_rdata !== 16'h0 || b_d_valid !== 1'b0) begin fails++; $display("FAIL lat3_quiet: got %h %b want 0000 0", b_if_rdata, b_d_valid); end
        b_if_req = 1'b1;
        @(negedge clk);
        tests++; if (b_if_gnt !== 1'b1) begin fails++; $display("FAIL mid3_gnt: got %b want 1", b_if_gnt); end
        next_cycle();
        b_if_req = 1'b0;
        next_cycle();
        b_reset = 1'b1;
        @(negedge clk);
        tests++; if (b_if_valid !== 1'b0) begin fails++; $display("FAIL mid3_valid_n2: got %b want 0", b_if_valid); end
        next_cycle();
        b_reset = 1'b0;
        @(negedge clk);
        tests++; if (b_if_valid !== 1'b0) begin fails++; $display("FAIL mid3_valid_n3: got %b want 0", b_if_valid); end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
        mem_a[1] = 16'h1000;
        mem_a[2] = 16'h8C00;
        mem_a[5] = 16'h0055;
        mem_a[1023] = 16'h5A5A;
        mem_b[1] = 16'h1000;
        next_cycle();
        test_reset();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_back_to_back();
        test_wrap_idle();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
